// File: rtl/event_dispatch_pkg.sv
// rtl/event_dispatch_pkg.sv - shared PDES types and default widths for event dispatch
// Contents: dispatcher FSM state encoding, default parameter values,
//           core-index width helper.
package event_dispatch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } disp_state_t;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_CMP_WID  = 32;
  localparam int DEF_NUM_CORE = 4;

  // A single core still needs a 1-bit index port.
  function automatic int core_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/event_dispatch_rr_arb.sv
// rtl/event_dispatch_rr_arb.sv - round-robin request selector
// Ports: req    - per-requester request vector
//        ptr    - index where the search starts (highest priority)
//        winner - first requesting index at or after ptr (wrapping)
//        any    - at least one request is set
module rr_arb #(
  parameter int N = 4,
  parameter int B = 2
) (
  input  logic [N-1:0] req,
  input  logic [B-1:0] ptr,
  output logic [B-1:0] winner,
  output logic         any
);

  int idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!any && req[idx]) begin
        winner = B'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/event_dispatch.sv
// rtl/event_dispatch.sv - hands the minimum-timestamp event to cores round-robin
// Ports: clk, rst_n                 - clock, async active-low reset
//        pq_out_data, pq_empty      - head of priority queue
//        pq_deq                     - dequeue strobe (combinational)
//        core_req                   - per-core level request
//        evt_valid/data/core, evt_ack - dispatched event handshake
//        last_ts, disp_cnt, order_err - dequeue statistics and ordering check
module event_dispatch
  import event_dispatch_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CMP_WID  = DEF_CMP_WID,
  parameter int NUM_CORE = DEF_NUM_CORE,
  localparam int CORE_BITS = core_bits(NUM_CORE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     pq_out_data,
  input  logic                 pq_empty,
  output logic                 pq_deq,
  input  logic [NUM_CORE-1:0]  core_req,
  output logic                 evt_valid,
  output logic [WIDTH-1:0]     evt_data,
  output logic [CORE_BITS-1:0] evt_core,
  input  logic                 evt_ack,
  output logic [CMP_WID-1:0]   last_ts,
  output logic [31:0]          disp_cnt,
  output logic                 order_err
);

  disp_state_t          state, state_next;
  logic [CORE_BITS-1:0] rr_ptr;
  logic [CORE_BITS-1:0] winner;
  logic                 any_req;
  logic                 first;
  logic [CMP_WID-1:0]   new_ts;

  assign new_ts = pq_out_data[CMP_WID-1:0];

  rr_arb #(.N(NUM_CORE), .B(CORE_BITS)) u_rr_arb (
    .req    (core_req),
    .ptr    (rr_ptr),
    .winner (winner),
    .any    (any_req)
  );

  always_comb begin
    state_next = state;
    pq_deq     = 1'b0;
    case (state)
      IDLE: begin
        // rst_n gating keeps the strobe low for the whole reset window.
        if (rst_n && any_req && !pq_empty) begin
          pq_deq     = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (evt_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_data  <= '0;
      evt_core  <= '0;
      last_ts   <= '0;
      disp_cnt  <= '0;
      order_err <= 1'b0;
      rr_ptr    <= '0;
      first     <= 1'b1;
    end else begin
      state     <= state_next;
      evt_valid <= (state_next == SEND);
      if (pq_deq) begin
        evt_data <= pq_out_data;
        evt_core <= winner;
        rr_ptr   <= (winner == CORE_BITS'(NUM_CORE - 1)) ? '0 : winner + CORE_BITS'(1);
        last_ts  <= new_ts;
        disp_cnt <= disp_cnt + 32'd1;
        first    <= 1'b0;
        // last_ts is meaningless before the first dequeue.
        if (!first && (new_ts < last_ts)) order_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_event_dispatch.sv
// tb/tb_event_dispatch.sv - scoreboard bench for event_dispatch
module tb_event_dispatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pq_out_data = '0;
  logic        pq_empty = 1'b1;
  logic        pq_deq;
  logic [3:0]  core_req = '0;
  logic        evt_valid;
  logic [31:0] evt_data;
  logic [1:0]  evt_core;
  logic        evt_ack = 1'b0;
  logic [31:0] last_ts;
  logic [31:0] disp_cnt;
  logic        order_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  core;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_cnt = 0;

  always #5 clk = ~clk;

  event_dispatch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pq_out_data (pq_out_data),
    .pq_empty    (pq_empty),
    .pq_deq      (pq_deq),
    .core_req    (core_req),
    .evt_valid   (evt_valid),
    .evt_data    (evt_data),
    .evt_core    (evt_core),
    .evt_ack     (evt_ack),
    .last_ts     (last_ts),
    .disp_cnt    (disp_cnt),
    .order_err   (order_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a dequeue seen before one edge must be presented after it.
  logic pending = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (pending) begin
      chk("mon_valid", 64'(evt_valid), 64'd1);
      if (exp_q.size() == 0) begin
        chk("mon_unexpected_event", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_data", 64'(evt_data), 64'(e.data));
        chk("mon_core", 64'(evt_core), 64'(e.core));
        chk("mon_cnt", 64'(disp_cnt), 64'(e.cnt));
      end
    end
    pending = pq_deq && rst_n;
  end

  task automatic push_exp(input logic [31:0] data, input logic [1:0] core);
    exp_t e;
    exp_cnt   = exp_cnt + 1;
    e.data    = data;
    e.core    = core;
    e.cnt     = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic send_evt(input logic [3:0] req, input logic [31:0] data,
                          input int ack_delay, input bit hold, input logic [1:0] core);
    @(negedge clk);
    core_req    = req;
    pq_empty    = 1'b0;
    pq_out_data = data;
    evt_ack     = 1'b0;
    push_exp(data, core);
    #1 chk("deq_strobe", 64'(pq_deq), 64'd1);
    @(negedge clk);
    if (!hold) core_req = '0;
    #1 chk("no_deq_in_send", 64'(pq_deq), 64'd0);
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", 64'(evt_valid), 64'd1);
      chk("hold_data", 64'(evt_data), 64'(data));
      chk("hold_core", 64'(evt_core), 64'(core));
      chk("hold_no_deq", 64'(pq_deq), 64'd0);
    end
    evt_ack = 1'b1;
    @(negedge clk);
    evt_ack  = 1'b0;
    pq_empty = 1'b1;
    if (!hold) core_req = '0;
    #1 chk("idle_valid_low", 64'(evt_valid), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    core_req = '0;
    pq_empty = 1'b1;
    evt_ack  = 1'b0;
    exp_cnt  = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values while inputs would otherwise request a dequeue.
    core_req = 4'b0001;
    pq_empty = 1'b0;
    #3;
    chk("rst_deq", 64'(pq_deq), 64'd0);
    chk("rst_valid", 64'(evt_valid), 64'd0);
    chk("rst_cnt", 64'(disp_cnt), 64'd0);
    chk("rst_err", 64'(order_err), 64'd0);
    do_reset();

    // Basic dispatch
    send_evt(4'b0001, 32'h10, 0, 1'b0, 2'd0);
    chk("basic_last_ts", 64'(last_ts), 64'h10);

    // Round-robin with all cores requesting
    do_reset();
    for (int i = 0; i < 8; i++)
      send_evt(4'b1111, 32'h100 + 32'(i), 0, 1'b1, 2'(i % 4));
    chk("rr_cnt", 64'(disp_cnt), 64'd8);

    // Empty queue blocks dispatch
    @(negedge clk);
    core_req = 4'b0100;
    pq_empty = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("empty_no_deq", 64'(pq_deq), 64'd0);
      chk("empty_no_valid", 64'(evt_valid), 64'd0);
      @(negedge clk);
    end
    send_evt(4'b0100, 32'h200, 0, 1'b0, 2'd2);

    // Long stall with request dropped; pointer is 3, only core 0 requests
    send_evt(4'b0001, 32'h300, 5, 1'b0, 2'd0);
    chk("stall_cnt", 64'(disp_cnt), 64'd10);

    // Ordering error detection
    do_reset();
    send_evt(4'b0001, 32'h20, 0, 1'b0, 2'd0);
    chk("ord_ts0", 64'(last_ts), 64'h20);
    chk("ord_err0", 64'(order_err), 64'd0);
    send_evt(4'b0001, 32'h18, 0, 1'b0, 2'd0);
    chk("ord_ts1", 64'(last_ts), 64'h18);
    chk("ord_err1", 64'(order_err), 64'd1);
    send_evt(4'b0001, 32'h30, 0, 1'b0, 2'd0);
    chk("ord_ts2", 64'(last_ts), 64'h30);
    chk("ord_err_sticky", 64'(order_err), 64'd1);

    // Reset in the middle of SEND; pointer is 1, only core 3 requests
    @(negedge clk);
    core_req    = 4'b1000;
    pq_empty    = 1'b0;
    pq_out_data = 32'h40;
    push_exp(32'h40, 2'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(evt_valid), 64'd0);
    chk("mid_rst_data", 64'(evt_data), 64'd0);
    chk("mid_rst_core", 64'(evt_core), 64'd0);
    chk("mid_rst_ts", 64'(last_ts), 64'd0);
    chk("mid_rst_cnt", 64'(disp_cnt), 64'd0);
    chk("mid_rst_err", 64'(order_err), 64'd0);
    chk("mid_rst_deq", 64'(pq_deq), 64'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    core_req = '0;
    pq_empty = 1'b1;
    exp_cnt  = 0;
    // Pointer must be back at 0: core 1 request wins as core 1, count restarts
    send_evt(4'b0010, 32'h55, 0, 1'b0, 2'd1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/event_dispatch.md
EVENT_DISPATCH -- requirements
Module: event_dispatch

Interface
REQ-001 SHALL have parameter WIDTH, default 32, event word width (matches priority-queue data port).
REQ-002 SHALL have parameter CMP_WID, default 32, timestamp field = CMP_WID LSBs of event word.
REQ-003 SHALL have parameter NUM_CORE, default 4, number of requesting cores; CORE_BITS = clog2(NUM_CORE).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port pq_out_data  input  WIDTH  current minimum event from priority queue (combinationally valid when pq_empty=0).
REQ-007 SHALL have port pq_empty  input  1  priority queue holds no events.
REQ-008 SHALL have port pq_deq  output  1  one-cycle dequeue strobe to priority queue.
REQ-009 SHALL have port core_req  input  NUM_CORE  per-core level request for next event.
REQ-010 SHALL have port evt_valid  output  1  dispatched event is presented.
REQ-011 SHALL have port evt_data  output  WIDTH  dispatched event word.
REQ-012 SHALL have port evt_core  output  CORE_BITS  index of core receiving evt_data.
REQ-013 SHALL have port evt_ack  input  1  granted core accepted evt_data.
REQ-014 SHALL have port last_ts  output  CMP_WID  timestamp of most recently dequeued event.
REQ-015 SHALL have port disp_cnt  output  32  count of events dequeued.
REQ-016 SHALL have port order_err  output  1  sticky flag: dequeued timestamp lower than last_ts.

Function
REQ-017 SHALL implement FSM with states IDLE and SEND.
REQ-018 In IDLE with |core_req=1 and pq_empty=0, SHALL assert pq_deq for exactly that cycle, capture pq_out_data into evt_data, capture round-robin winner into evt_core, and move to SEND.
REQ-019 In IDLE with core_req=0 or pq_empty=1, SHALL keep pq_deq=0 and remain IDLE; pq_deq SHALL never be 1 while pq_empty=1.
REQ-020 In SEND, evt_valid SHALL be 1 and evt_data/evt_core SHALL hold stable until evt_ack=1.
REQ-021 On evt_ack=1 in SEND, SHALL return to IDLE next cycle; evt_ack in IDLE SHALL be ignored.
REQ-022 Request-to-evt_valid latency SHALL be 1 cycle; peak throughput SHALL be one event per 2 cycles.
REQ-023 Deassertion of the granted core's core_req during SEND SHALL NOT cancel the dispatch.
REQ-024 Arbitration SHALL be round-robin: search starts at pointer, pointer SHALL advance to winner+1 (mod NUM_CORE) on each dequeue; pointer reset value 0.
REQ-025 On each dequeue, last_ts SHALL load pq_out_data[CMP_WID-1:0] and disp_cnt SHALL increment, wrapping 2^32-1 -> 0.
REQ-026 On each dequeue after the first since reset, if new timestamp < last_ts (unsigned), order_err SHALL set and stay set until reset.
REQ-027 evt_valid SHALL be 0 in IDLE; evt_data/evt_core hold last values.

Reset
REQ-028 On rst_n=0, SHALL asynchronously force state=IDLE, evt_valid=0, pq_deq=0, evt_data=0, evt_core=0, last_ts=0, disp_cnt=0, order_err=0, rr pointer=0, first-flag=1.
REQ-029 Reset during SEND SHALL drop the held event (already dequeued); no re-enqueue.

Structure
REQ-030 FSM state encoding and default widths SHALL live in the shared PDES package.
REQ-031 Round-robin selection SHALL be a sub-module rr_arb (inputs req, pointer; outputs winner index, any).
REQ-032 pq_deq SHALL be combinational from IDLE state, core_req, pq_empty; all other outputs registered.

Verification
REQ-033 Reset then core_req=4'b0001, pq_empty=0, pq_out_data=0x10 -> pq_deq one cycle, next cycle evt_valid=1, evt_data=0x10, evt_core=0, disp_cnt=1.
REQ-034 core_req=4'b1111 held, ack every SEND cycle, 8 events -> evt_core sequence 0,1,2,3,0,1,2,3, disp_cnt=8.
REQ-035 pq_empty=1 with core_req=4'b0100 for 10 cycles -> pq_deq=0, evt_valid=0 throughout; pq_empty=0 -> dispatch to core 2 next cycle.
REQ-036 SEND with evt_ack=0 for 5 cycles and core_req dropped -> evt_valid/evt_data stable, no second pq_deq; ack -> IDLE.
REQ-037 Dequeue timestamps 0x20 then 0x18 -> last_ts=0x18, order_err=1 and stays 1; rst_n pulse mid-SEND -> all outputs at reset values.
